// File: rtl/myproject_mul_share_arb_if.sv
// Request/response bundle between the compute engines and the shared multiplier arbiter.
// The arbiter takes the slave view; engines and responders take the master view.
interface myproject_mul_share_arb_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int A_W   = 16,
   parameter int B_W   = 10,
   parameter int P_W   = 26
);
   logic [N_REQ-1:0]     req_valid;
   logic [N_REQ-1:0]     req_ready;
   logic [N_REQ*A_W-1:0] req_a;
   logic [N_REQ*B_W-1:0] req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [P_W-1:0]       rsp_data;
   logic [1:0]           in_flight;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, in_flight
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, in_flight
   );
endinterface

// File: rtl/myproject_mul_share_arb.sv
// Round-robin arbiter feeding one shared 16s x 10u multiplier through a two-stage pipeline.
// Products come back in acceptance order, tagged with the requester id.
module myproject_mul_share_arb #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int A_W   = 16,
   parameter int B_W   = 10,
   parameter int P_W   = 26
) (
   input  logic                       clk,
   input  logic                       reset,
   myproject_mul_share_arb_if.slave   bus
);

   logic [A_W-1:0]        a_arr [N_REQ];
   logic [B_W-1:0]        b_arr [N_REQ];

   logic                  ce;
   logic                  gnt_found;
   logic [ID_W-1:0]       gnt_id;
   logic [ID_W-1:0]       scan_idx;
   logic                  accept;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

   logic                  v1_q, v2_q;
   logic [ID_W-1:0]       id1_q, id2_q;
   logic [A_W-1:0]        a1_q;
   logic [B_W-1:0]        b1_q;
   logic signed [P_W-1:0] a_ext, b_ext;
   logic [P_W-1:0]        prod_q, prod_d;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_lane
         assign a_arr[gi]         = bus.req_a[gi*A_W +: A_W];
         assign b_arr[gi]         = bus.req_b[gi*B_W +: B_W];
         assign bus.req_ready[gi] = accept && (gnt_id == ID_W'(gi));
      end
   endgenerate

   // A stalled response freezes both stages, so nothing may be accepted either.
   assign ce     = !(v2_q && !bus.rsp_ready);
   assign accept = gnt_found && ce && !reset;

   // Scan downward so the requester closest to rr_ptr is the last (winning) match.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      scan_idx  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         scan_idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
         if (bus.req_valid[scan_idx]) begin
            gnt_found = 1'b1;
            gnt_id    = scan_idx;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
      end
   end

   // Operand B is zero-extended, so the full-width signed product never overflows.
   always_comb begin
      a_ext  = {{B_W{a1_q[A_W-1]}}, a1_q};
      b_ext  = {{A_W{1'b0}}, b1_q};
      prod_d = a_ext * b_ext;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         id1_q    <= '0;
         id2_q    <= '0;
         a1_q     <= '0;
         b1_q     <= '0;
         prod_q   <= '0;
      end else if (ce) begin
         rr_ptr_q <= rr_ptr_d;
         v1_q     <= accept;
         if (accept) begin
            a1_q  <= a_arr[gnt_id];
            b1_q  <= b_arr[gnt_id];
            id1_q <= gnt_id;
         end
         v2_q   <= v1_q;
         id2_q  <= id1_q;
         prod_q <= prod_d;
      end
   end

   assign bus.rsp_valid = v2_q;
   assign bus.rsp_id    = id2_q;
   assign bus.rsp_data  = prod_q;
   assign bus.in_flight = {1'b0, v1_q} + {1'b0, v2_q};

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Self-checking bench: directed sequences, a product table and a randomized run,
// all scored against a queue-based model of accepted-but-unconsumed requests.
module tb_myproject_mul_share_arb;
   localparam int N_REQ = 4;
   localparam int ID_W  = 2;
   localparam int A_W   = 16;
   localparam int B_W   = 10;
   localparam int P_W   = 26;

   logic clk;
   logic reset;

   myproject_mul_share_arb_if #(.N_REQ(N_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)) bus ();

   myproject_mul_share_arb #(.N_REQ(N_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   longint edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      int     id;
      longint prod;
      longint acc;
   } item_t;

   typedef struct {
      logic signed [A_W-1:0] a;
      logic [B_W-1:0]        b;
      longint                exp;
   } vec_t;

   item_t   q[$];
   int      ptr;
   int      n_chk;
   int      n_fail;
   bit      got_rsp;
   longint  last_rsp;
   int      last_id;
   logic [N_REQ-1:0] last_ready;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic signed [A_W-1:0] a, input logic [B_W-1:0] b);
      bus.req_a[i*A_W +: A_W] = a;
      bus.req_b[i*B_W +: B_W] = b;
   endtask

   // One clock of the model: inputs are already driven; judge outputs at the falling edge,
   // then account for whatever the next rising edge will transfer.
   task automatic run_cycle();
      bit     exp_rv;
      bit     ce;
      int     g;
      int     idx;
      longint av;
      longint bv;
      logic [N_REQ-1:0] exp_ready;
      item_t  it;
      @(negedge clk);
      got_rsp = 1'b0;
      // The oldest item reaches the output one edge after it was accepted and waits there.
      exp_rv = (q.size() > 0) && (edge_cnt >= q[0].acc + 1);
      chk("rsp_valid", bus.rsp_valid, exp_rv);
      chk("in_flight", bus.in_flight, q.size());
      if (exp_rv) begin
         chk("rsp_id", bus.rsp_id, q[0].id);
         chk("rsp_data", $signed(bus.rsp_data), q[0].prod);
      end
      ce = !(exp_rv && !bus.rsp_ready);
      g = -1;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (ptr + k) % N_REQ;
         if (bus.req_valid[idx] && g < 0) g = idx;
      end
      exp_ready = (ce && g >= 0) ? N_REQ'(1 << g) : '0;
      chk("req_ready", bus.req_ready, exp_ready);
      last_ready = bus.req_ready;
      if (exp_rv && bus.rsp_ready) begin
         last_rsp = $signed(bus.rsp_data);
         last_id  = int'(bus.rsp_id);
         got_rsp  = 1'b1;
         void'(q.pop_front());
      end
      if (ce && g >= 0) begin
         av = longint'($signed(bus.req_a[g*A_W +: A_W]));
         bv = longint'(bus.req_b[g*B_W +: B_W]);
         it.id   = g;
         it.prod = av * bv;
         it.acc  = edge_cnt + 1;
         q.push_back(it);
         ptr = (g + 1) % N_REQ;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      chk("ready_in_reset", bus.req_ready, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      q.delete();
      ptr = 0;
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_in_flight", bus.in_flight, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
   endtask

   task automatic drain(input int n);
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   vec_t vecs [6];
   logic [P_W-1:0] held_data;
   logic [ID_W-1:0] held_id;

   initial begin
      n_chk = 0;
      n_fail = 0;
      ptr = 0;
      vecs[0] = '{a: -16'sd3,     b: 10'd1023, exp: -64'sd3069};
      vecs[1] = '{a: -16'sd32768, b: 10'd1023, exp: -64'sd33521664};
      vecs[2] = '{a: 16'sd32767,  b: 10'd1023, exp: 64'sd33520641};
      vecs[3] = '{a: 16'sd1234,   b: 10'd0,    exp: 64'sd0};
      vecs[4] = '{a: -16'sd1,     b: 10'd1,    exp: -64'sd1};
      vecs[5] = '{a: 16'sd100,    b: 10'd7,    exp: 64'sd700};

      bus.req_valid = '1;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.rsp_ready = 1'b1;
      do_reset();

      // Two back-to-back requests from requester 0: occupancy 1,2,1,0.
      set_req(0, -16'sd3, 10'd1023);
      bus.req_valid = 4'b0001;
      run_cycle();
      chk("seq_if_1", bus.in_flight, 1);
      set_req(0, 16'sd5, 10'd2);
      run_cycle();
      chk("seq_if_2", bus.in_flight, 2);
      bus.req_valid = '0;
      run_cycle();
      chk("seq_if_3", bus.in_flight, 1);
      chk("seq_first_rsp", last_rsp, -3069);
      chk("seq_first_id", last_id, 0);
      run_cycle();
      chk("seq_if_4", bus.in_flight, 0);
      chk("seq_second_rsp", last_rsp, 10);

      // Product table through requester 0, one at a time.
      foreach (vecs[v]) begin
         set_req(0, vecs[v].a, vecs[v].b);
         bus.req_valid = 4'b0001;
         run_cycle();
         bus.req_valid = '0;
         for (int w = 0; w < 4; w++) begin
            run_cycle();
            if (got_rsp) break;
         end
         chk("tbl_got_rsp", got_rsp, 1);
         chk("tbl_product", last_rsp, vecs[v].exp);
      end

      // All four requesters held valid: strict rotation from pointer 0.
      do_reset();
      for (int i = 0; i < N_REQ; i++) set_req(i, A_W'(i * 111 - 200), B_W'(i * 37 + 5));
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         run_cycle();
         chk("rr_all_grant", last_ready, 1 << (k % 4));
      end
      drain(3);

      // Pointer at 2 with requesters 1 and 3 waiting: 3 wins, then the wrap to 0 lets 1 in.
      bus.req_valid = 4'b0010;
      run_cycle();
      chk("rr_prep_grant", last_ready, 4'b0010);
      bus.req_valid = 4'b1010;
      run_cycle();
      chk("rr_wrap_first", last_ready, 4'b1000);
      run_cycle();
      chk("rr_wrap_second", last_ready, 4'b0010);
      drain(3);

      // Backpressure on a stream from requester 2.
      bus.req_valid = 4'b0100;
      set_req(2, 16'sd1000, 10'd3);
      run_cycle();
      set_req(2, -16'sd77, 10'd512);
      run_cycle();
      held_data = bus.rsp_data;
      held_id = bus.rsp_id;
      bus.rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_req(2, A_W'(k * 9 + 1), B_W'(k + 2));
         run_cycle();
         chk("bp_ready_zero", last_ready, 0);
         chk("bp_in_flight", bus.in_flight, 2);
         chk("bp_data_stable", bus.rsp_data, held_data);
         chk("bp_id_stable", bus.rsp_id, held_id);
      end
      bus.rsp_ready = 1'b1;
      run_cycle();
      chk("bp_release_rsp", last_rsp, 3000);
      run_cycle();
      drain(4);
      chk("bp_drained", q.size(), 0);

      // Randomized traffic with random backpressure.
      for (int c = 0; c < 400; c++) begin
         bus.req_valid = N_REQ'($urandom_range(0, 15));
         for (int i = 0; i < N_REQ; i++) set_req(i, A_W'($urandom), B_W'($urandom));
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         run_cycle();
      end
      drain(4);
      chk("rand_drained", q.size(), 0);

      // Reset with the pipeline full discards both entries.
      bus.req_valid = 4'b0001;
      bus.rsp_ready = 1'b0;
      set_req(0, 16'sd21, 10'd21);
      run_cycle();
      run_cycle();
      chk("mid_full", bus.in_flight, 2);
      do_reset();
      drain(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
